// File: rtl/id_ex_stage_if.sv
// ID-side bundle feeding the ID/EX pipeline register.
// master = decode stage, slave = id_ex_stage.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              id_valid_i;
  logic [XLEN-1:0]   id_pc_i;
  logic [XLEN-1:0]   id_rd1_i;
  logic [XLEN-1:0]   id_rd2_i;
  logic [XLEN-1:0]   id_imm_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_alu_src_i;
  logic [3:0]        id_alu_control_i;
  logic              id_reg_write_i;
  logic              id_mem_write_i;
  logic [1:0]        id_result_src_i;

  modport master (
    output id_valid_i, id_pc_i, id_rd1_i, id_rd2_i,
    output id_imm_i, id_rs1_i, id_rs2_i, id_rd_i,
    output id_alu_src_i, id_alu_control_i,
    output id_reg_write_i, id_mem_write_i,
    output id_result_src_i
  );

  modport slave (
    input id_valid_i, id_pc_i, id_rd1_i, id_rd2_i,
    input id_imm_i, id_rs1_i, id_rs2_i, id_rd_i,
    input id_alu_src_i, id_alu_control_i,
    input id_reg_write_i, id_mem_write_i,
    input id_result_src_i
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU.
// Forwarding is built only when ID_EX_FORWARD_EN is defined.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  id_ex_stage_if.slave      id,
  input  logic [REG_AW-1:0] exm_rd_i,
  input  logic              exm_reg_write_i,
  input  logic [XLEN-1:0]   exm_result_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_write_i,
  input  logic [XLEN-1:0]   wb_result_i,
  output logic [XLEN-1:0]   src_a_o,
  output logic [XLEN-1:0]   src_b_o,
  output logic [3:0]        alu_control_o,
  output logic [XLEN-1:0]   write_data_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              reg_write_o,
  output logic              mem_write_o,
  output logic [1:0]        result_src_o,
  output logic              valid_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  logic              valid_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   rd1_q;
  logic [XLEN-1:0]   rd2_q;
  logic [XLEN-1:0]   imm_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rd_q;
  logic              alu_src_q;
  logic [3:0]        alu_ctrl_q;
  logic              reg_write_q;
  logic              mem_write_q;
  logic [1:0]        result_src_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
    end else if (flush_i) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
    end else if (!stall_i) begin
      valid_q      <= id.id_valid_i;
      pc_q         <= id.id_pc_i;
      rd1_q        <= id.id_rd1_i;
      rd2_q        <= id.id_rd2_i;
      imm_q        <= id.id_imm_i;
      rs1_q        <= id.id_rs1_i;
      rs2_q        <= id.id_rs2_i;
      rd_q         <= id.id_rd_i;
      alu_src_q    <= id.id_alu_src_i;
      alu_ctrl_q   <= id.id_alu_control_i;
      // side effects only from real instructions
      reg_write_q  <= id.id_valid_i & id.id_reg_write_i;
      mem_write_q  <= id.id_valid_i & id.id_mem_write_i;
      result_src_q <= id.id_result_src_i;
    end
  end

`ifdef ID_EX_FORWARD_EN
  function automatic logic [1:0] fwd_sel(
    input logic              v,
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] e_rd,
    input logic              e_we,
    input logic [REG_AW-1:0] w_rd,
    input logic              w_we
  );
    logic [1:0] s;
    s = 2'b00;
    if (v && rs != '0) begin
      if (e_we && e_rd == rs)      s = 2'b10;
      else if (w_we && w_rd == rs) s = 2'b01;
    end
    return s;
  endfunction

  always_comb begin
    fwd_a_o = fwd_sel(valid_q, rs1_q, exm_rd_i,
                      exm_reg_write_i, wb_rd_i,
                      wb_reg_write_i);
    fwd_b_o = fwd_sel(valid_q, rs2_q, exm_rd_i,
                      exm_reg_write_i, wb_rd_i,
                      wb_reg_write_i);
  end

  always_comb begin
    src_a_o = rd1_q;
    unique case (1'b1)
      fwd_a_o[1]: src_a_o = exm_result_i;
      fwd_a_o[0]: src_a_o = wb_result_i;
      default:    src_a_o = rd1_q;
    endcase
  end

  always_comb begin
    write_data_o = rd2_q;
    unique case (1'b1)
      fwd_b_o[1]: write_data_o = exm_result_i;
      fwd_b_o[0]: write_data_o = wb_result_i;
      default:    write_data_o = rd2_q;
    endcase
  end
`else
  // hazard unit stalls every RAW hazard in this build
  logic unused_fwd;
  assign unused_fwd = ^{exm_rd_i, exm_reg_write_i,
                        exm_result_i, wb_rd_i,
                        wb_reg_write_i, wb_result_i,
                        rs1_q, rs2_q};

  assign fwd_a_o      = 2'b00;
  assign fwd_b_o      = 2'b00;
  assign src_a_o      = rd1_q;
  assign write_data_o = rd2_q;
`endif

  assign src_b_o       = alu_src_q ? imm_q : write_data_o;
  assign alu_control_o = alu_ctrl_q;
  assign pc_o          = pc_q;
  assign rd_o          = rd_q;
  assign reg_write_o   = reg_write_q;
  assign mem_write_o   = mem_write_q;
  assign result_src_o  = result_src_q;
  assign valid_o       = valid_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the ALU in the 5-stage RISC-V pipeline.
- Registers decoded operands and control from ID, resolves data forwarding from the EX/MEM and MEM/WB stages, and drives the ALU's A/B operands and 4-bit ALU control.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register index width

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- stall_i  input  1  hold the current register contents
- flush_i  input  1  replace the next contents with a bubble
- id_valid_i  input  1  ID holds a real instruction
- id_pc_i  input  XLEN  instruction PC
- id_rd1_i  input  XLEN  register-file read data for rs1
- id_rd2_i  input  XLEN  register-file read data for rs2
- id_imm_i  input  XLEN  sign-extended immediate
- id_rs1_i  input  REG_AW  source register index 1
- id_rs2_i  input  REG_AW  source register index 2
- id_rd_i  input  REG_AW  destination register index
- id_alu_src_i  input  1  1 = B operand from immediate
- id_alu_control_i  input  4  ALU operation code
- id_reg_write_i  input  1  instruction writes the register file
- id_mem_write_i  input  1  instruction is a store
- id_result_src_i  input  2  writeback source select
- exm_rd_i  input  REG_AW  EX/MEM destination register
- exm_reg_write_i  input  1  EX/MEM writes the register file
- exm_result_i  input  XLEN  EX/MEM ALU result
- wb_rd_i  input  REG_AW  MEM/WB destination register
- wb_reg_write_i  input  1  MEM/WB writes the register file
- wb_result_i  input  XLEN  MEM/WB writeback value
- src_a_o  output  XLEN  ALU A operand
- src_b_o  output  XLEN  ALU B operand
- alu_control_o  output  4  registered ALU operation code
- write_data_o  output  XLEN  forwarded rs2 value, used as store data
- pc_o  output  XLEN  registered PC
- rd_o  output  REG_AW  registered destination register
- reg_write_o  output  1  registered reg-write control
- mem_write_o  output  1  registered mem-write control
- result_src_o  output  2  registered writeback source select
- valid_o  output  1  stage holds a real instruction
- fwd_a_o  output  2  forward select for A: 00 register file, 10 EX/MEM, 01 WB
- fwd_b_o  output  2  forward select for B (rs2 path), same encoding

Behaviour:
- Reset (rst=0, asynchronous): every register clears to 0, so valid_o=0, reg_write_o=0, mem_write_o=0, alu_control_o=0, pc_o=0, rd_o=0.
  - Combinational outputs then read src_a_o=0, src_b_o=0, write_data_o=0, fwd_a_o=fwd_b_o=00.
  - A reset asserted mid-operation discards the in-flight instruction.
- Latency: ID inputs appear on the registered outputs one cycle after capture.
- Edge update priority: flush_i > stall_i > load.
  - flush_i=1: bubble. valid=0, reg_write=0, mem_write=0, all other fields cleared. Flush wins when stall is also high.
  - stall_i=1, flush_i=0: all registers hold their values.
  - Otherwise all ID fields are captured; valid = id_valid_i.
  - With id_valid_i=0, reg_write and mem_write are captured as 0 regardless of their inputs.
- Forwarding (combinational from the registered rs1/rs2 and the live EX/MEM and WB inputs), rs1 path:
  - EX/MEM wins when exm_reg_write_i=1, exm_rd_i!=0 and exm_rd_i==rs1; select 10.
  - Else WB wins when wb_reg_write_i=1, wb_rd_i!=0 and wb_rd_i==rs1; select 01.
  - Else register file; select 00.
- rs2 path uses the same rule. Index x0 is never forwarded.
- Forwarding is evaluated only when valid=1; when valid=0, both selects are 00.
- src_a_o = forwarded rs1 value.
- write_data_o = forwarded rs2 value.
- src_b_o = id_imm (registered) when alu_src=1, else write_data_o.
- Store data is always forwarded, even when alu_src=1.
- No arithmetic is done in this block; widths pass through unchanged.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding behaves as specified above.
- Undefined: forwarding logic is removed. fwd_a_o and fwd_b_o are tied to 00, src_a_o and write_data_o come directly from the registered rd1/rd2, and the hazard unit is responsible for stalling all RAW hazards.

Test Plan:
- Reset: rst=0 during operation -> on the same cycle, valid_o=0, reg_write_o=0, src_a_o=0, with no clock edge required.
- Load: rd1=0x0000_0005, imm=0x0000_000C, alu_src=1, alu_control=0000 -> next cycle src_a_o=5, src_b_o=0xC, alu_control_o=0000, valid_o=1.
- EX/MEM forward: registered rs1=3, exm_rd=3, exm_reg_write=1, exm_result=0xDEAD_BEEF -> src_a_o=0xDEAD_BEEF, fwd_a_o=10.
- Forward priority: rs2=4, exm_rd=4 with result 0x11, wb_rd=4 with result 0x22, alu_src=0 -> src_b_o=0x11, fwd_b_o=10.
- x0 never forwarded: rs1=0, exm_rd=0, exm_reg_write=1, exm_result=0x55 -> fwd_a_o=00, src_a_o = registered rd1.
- Stall and flush: stall=1 for 2 cycles with changing ID inputs -> outputs unchanged; then stall=1 and flush=1 together -> valid_o=0, reg_write_o=0, mem_write_o=0 next cycle.
